// File: rtl/fetch_unit_pkg.sv
// Shared IF-stage defaults: address/data widths, reset PC and sequential step,
// used by the fetch unit, the instruction memory and the PC logic.
package fetch_unit_pkg;

  localparam int          IF_ADDR_W   = 32;
  localparam int          IF_DATA_W   = 32;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam int          IF_PC_STEP  = 1;
  localparam int          IF_DEPTH    = 4;

endpackage

// File: rtl/fetch_queue.sv
// Registered circular buffer of fetched {pc, instr} entries. The head entry is
// presented combinationally from storage; there is no fall-through path.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [W-1:0]                 head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Push and pop on a full queue is legal: rd and wr point at the same slot.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && count == CW'(DEPTH)));
`endif

endmodule

// File: rtl/fetch_unit.sv
// IF-stage fetch initiator: issues word addresses to a 1-cycle synchronous
// instruction memory, queues returned words with their PCs and hands them to ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter int                DATA_W   = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC),
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(IF_PC_STEP),
  parameter int                DEPTH    = IF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = CW + 2;

  // ID handshake: an instruction transfers on any edge where if_valid and
  // if_ready are both high; while if_valid is high and if_ready is low the
  // if_* outputs stay stable. A redirect cancels the transfer on that edge.

  logic                     addr_live;
  logic                     rsp_live;
  logic [ADDR_W-1:0]        rsp_pc;
  logic                     push;
  logic                     pop;
  logic                     issue;
  logic [NW-1:0]            need;
  logic [CW-1:0]            q_count;
  logic [ADDR_W+DATA_W-1:0] head;

  assign push     = rsp_live & ~redirect_valid;
  assign pop      = if_valid & if_ready & ~redirect_valid;
  assign if_valid = (q_count != '0);
  assign if_pc    = head[ADDR_W+DATA_W-1:DATA_W];
  assign if_instr = head[DATA_W-1:0];

  // Credit: every read in flight plus the one about to issue must have a slot.
  assign need  = NW'(q_count) + NW'(rsp_live) + NW'(addr_live) + NW'(1) - NW'(pop);
  assign issue = (need <= NW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr <= RESET_PC;
      addr_live <= 1'b1;
      rsp_live  <= 1'b0;
      rsp_pc    <= '0;
    end else begin
      rsp_live <= addr_live & ~redirect_valid;
      rsp_pc   <= imem_addr;
      if (redirect_valid) begin
        imem_addr <= redirect_target;
        addr_live <= 1'b1;
      end else if (issue) begin
        imem_addr <= imem_addr + PC_STEP;
        addr_live <= 1'b1;
      end else begin
        addr_live <= 1'b0;
      end
    end
  end

  fetch_queue #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({rsp_pc, imem_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head),
    .count     (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model mem[a] = A0000000 | a, expected PC stream
// queued by the driver and consumed by an independent output monitor.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_target;
  logic        w_if_valid;
  logic        w_if_ready;
  logic [31:0] w_if_instr;
  logic [31:0] w_if_pc;

  logic [31:0] exp_q[$];
  logic [31:0] wrap_q[$];
  logic [31:0] next_exp;
  int          total = 0;
  int          bad = 0;
  int          accepts = 0;
  bit          found;

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) u_wrap (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (w_imem_addr),
    .imem_data       (w_imem_data),
    .redirect_valid  (w_redirect_valid),
    .redirect_target (w_redirect_target),
    .if_valid        (w_if_valid),
    .if_ready        (w_if_ready),
    .if_instr        (w_if_instr),
    .if_pc           (w_if_pc)
  );

  always_ff @(posedge clk) begin
    imem_data   <= 32'hA000_0000 | imem_addr;
    w_imem_data <= 32'hA000_0000 | w_imem_addr;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_exp);
      next_exp = next_exp + 32'd1;
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      top_up();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    exp_q.delete();
    next_exp = t;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!rst && if_valid && if_ready && !redirect_valid) begin
      logic [31:0] e;
      accepts++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got pc %h with no expected entry", if_pc);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", if_pc, e);
        check("out_instr", if_instr, 32'hA000_0000 | e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && w_if_valid && wrap_q.size() != 0) begin
      logic [31:0] e;
      e = wrap_q.pop_front();
      check("wrap_pc", w_if_pc, e);
      check("wrap_instr", w_if_instr, 32'hA000_0000 | e);
    end
  end

  // ---------------- driver ----------------
  initial begin
    rst               = 1'b1;
    if_ready          = 1'b1;
    redirect_valid    = 1'b0;
    redirect_target   = '0;
    w_if_ready        = 1'b1;
    w_redirect_valid  = 1'b0;
    w_redirect_target = '0;
    next_exp          = 32'h0;
    wrap_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFFE);

    // Release between edges; first output after the 2nd edge.
    rst = 1'b0;
    step();
    check("lat_edge1_valid", {31'b0, if_valid}, 32'd0);
    step();
    check("lat_edge2_valid", {31'b0, if_valid}, 32'd1);
    check("lat_edge2_pc", if_pc, 32'd0);

    // Stall at pc 5 for 10 cycles.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (if_valid && if_pc == 32'd5) found = 1'b1;
    end
    check("wait_pc5", {31'b0, found}, 32'd1);
    if_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_valid", {31'b0, if_valid}, 32'd1);
      check("stall_pc", if_pc, 32'd5);
      check("stall_instr", if_instr, 32'hA000_0005);
    end
    if_ready = 1'b1;
    step(12);

    // Redirect to 0x40 with a partly filled queue.
    if_ready = 1'b0;
    step(3);
    if_ready = 1'b1;
    redirect_to(32'h40);
    step();
    redirect_valid = 1'b0;
    check("redir_e0_valid", {31'b0, if_valid}, 32'd0);
    step();
    check("redir_e1_valid", {31'b0, if_valid}, 32'd0);
    step();
    check("redir_e2_valid", {31'b0, if_valid}, 32'd1);
    check("redir_e2_pc", if_pc, 32'h40);
    check("redir_e2_instr", if_instr, 32'hA000_0040);
    step(6);

    // Back-to-back redirects: 0x10 must never appear.
    redirect_to(32'h10);
    step();
    redirect_to(32'h80);
    step();
    redirect_valid = 1'b0;
    check("dbl_valid", {31'b0, if_valid}, 32'd0);
    step(2);
    check("dbl_valid2", {31'b0, if_valid}, 32'd1);
    check("dbl_pc", if_pc, 32'h80);
    step(6);

    // Random ready/redirect with a mid-run reset.
    accepts = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        redirect_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        next_exp = 32'h0;
        #1;
        check("midrst_valid", {31'b0, if_valid}, 32'd0);
        check("midrst_addr", imem_addr, 32'd0);
        step(2);
        rst = 1'b0;
      end
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) redirect_to($urandom);
        else redirect_to(32'hFFFF_FFFF - $urandom_range(0, 3));
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    step(10);
    check("rand_accepts_min", {31'b0, (accepts > 3000)}, 32'd1);
    check("wrap_all_seen", wrap_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

endmodule
